// File: rtl/i2s_audio_in_pkg.sv
// Shared types and constants for the I2S capture path.
package i2s_audio_in_pkg;

    localparam int   AUDIO_DW      = 16;
    localparam int   MAX_SLOT_BITS = 63;
    localparam int   CNT_W         = 6;
    localparam logic LR_LEFT       = 1'b0;

    typedef logic [AUDIO_DW-1:0] sample_t;
    typedef logic [CNT_W-1:0]    bitcnt_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Left-align a slot of n received bits (1..AUDIO_DW); short slots get zero LSBs.
    function automatic sample_t align_word(input sample_t sreg, input bitcnt_t n);
        return sreg << (AUDIO_DW - int'(n));
    endfunction

endpackage

// File: rtl/i2s_audio_in_if.sv
// Pin side and sample side of the I2S receiver, bundled for port connection.
interface i2s_audio_in_if;
    import i2s_audio_in_pkg::*;

    logic    i2s_bclk;
    logic    i2s_lrclk;
    logic    i2s_data;
    sample_t left_out;
    sample_t right_out;
    logic    sample_valid;
    logic    locked;
    logic    frame_err;

    modport master (
        input  i2s_bclk, i2s_lrclk, i2s_data,
        output left_out, right_out, sample_valid, locked, frame_err
    );

    modport slave (
        output i2s_bclk, i2s_lrclk, i2s_data,
        input  left_out, right_out, sample_valid, locked, frame_err
    );

endinterface

// File: rtl/i2s_audio_in_rx_sync.sv
// Synchroniser for the three I2S pins plus a registered BCLK rise strobe.
// lrclk/data leave on the same cycle as the rise they belong to.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bclk_i,
    input  logic lrclk_i,
    input  logic data_i,
    output logic rise_o,
    output logic lrclk_o,
    output logic data_o
);

    logic [SYNC_STAGES-1:0] bclk_q, lrclk_q, data_q;
    logic                   bclk_prev_q, rise_q, lrclk_s_q, data_s_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_q      <= '0;
            lrclk_q     <= '0;
            data_q      <= '0;
            bclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            lrclk_s_q   <= 1'b0;
            data_s_q    <= 1'b0;
        end else begin
            bclk_q      <= {bclk_q[SYNC_STAGES-2:0], bclk_i};
            lrclk_q     <= {lrclk_q[SYNC_STAGES-2:0], lrclk_i};
            data_q      <= {data_q[SYNC_STAGES-2:0], data_i};
            bclk_prev_q <= bclk_q[SYNC_STAGES-1];
            rise_q      <= bclk_q[SYNC_STAGES-1] & ~bclk_prev_q;
            lrclk_s_q   <= lrclk_q[SYNC_STAGES-1];
            data_s_q    <= data_q[SYNC_STAGES-1];
        end
    end

    assign rise_o  = rise_q;
    assign lrclk_o = lrclk_s_q;
    assign data_o  = data_s_q;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S (Philips) stereo receiver: oversampled pins, slot assembly, frame pairing
// and a BCLK-loss timeout, all in the clk domain.
module i2s_audio_in
    import i2s_audio_in_pkg::*;
#(
    parameter int CLK_RATE       = 50000000,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic            clk,
    input logic            reset_n,
    i2s_audio_in_if.master bus
);

    if (SYNC_STAGES < 2 || CLK_RATE < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("i2s_audio_in: invalid parameter set");
    end

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam bitcnt_t           DW_CNT     = bitcnt_t'(AUDIO_DW);
    localparam bitcnt_t           MAX_CNT    = bitcnt_t'(MAX_SLOT_BITS);
    localparam bitcnt_t           CNT_ONE    = bitcnt_t'(1);

    logic rise, lrclk_s, data_s;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .bclk_i  (bus.i2s_bclk),
        .lrclk_i (bus.i2s_lrclk),
        .data_i  (bus.i2s_data),
        .rise_o  (rise),
        .lrclk_o (lrclk_s),
        .data_o  (data_s)
    );

    sample_t           sreg_q, sreg_d, left_hold_q, left_hold_d;
    stereo_t           out_q, out_d;
    bitcnt_t           bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              lr_prev_q, lr_prev_d, seen_q, seen_d, slot_ok_q, slot_ok_d;
    logic              left_ok_q, left_ok_d, locked_q, locked_d;
    logic              valid_q, valid_d, ferr_q, ferr_d;

    sample_t shifted, word;
    bitcnt_t n_bits;
    logic    slot_end;

    // The bit taken on the slot-ending rise still belongs to the old slot.
    always_comb begin
        shifted  = (bit_cnt_q < DW_CNT) ? {sreg_q[AUDIO_DW-2:0], data_s} : sreg_q;
        n_bits   = (bit_cnt_q < DW_CNT) ? bit_cnt_q + CNT_ONE : DW_CNT;
        word     = align_word(shifted, n_bits);
        slot_end = rise && (lrclk_s != lr_prev_q);
    end

    always_comb begin
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        lr_prev_d   = lr_prev_q;
        seen_d      = seen_q;
        slot_ok_d   = slot_ok_q;
        left_ok_d   = left_ok_q;
        left_hold_d = left_hold_q;
        out_d       = out_q;
        locked_d    = locked_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        idle_d      = (idle_q == IDLE_LIMIT) ? idle_q : idle_q + IDLE_ONE;

        if (rise) begin
            idle_d = '0;
            if (slot_end) begin
                // slot_ok_q: this slot opened at a transition seen after lock-up began
                ferr_d = slot_ok_q && (n_bits < DW_CNT);
                if (lr_prev_q == LR_LEFT) begin
                    left_ok_d = slot_ok_q;
                    if (slot_ok_q)
                        left_hold_d = word;
                end else begin
                    if (slot_ok_q && left_ok_q) begin
                        out_d.left  = left_hold_q;
                        out_d.right = word;
                        valid_d     = 1'b1;
                        locked_d    = 1'b1;
                    end
                    left_ok_d = 1'b0;
                end
                slot_ok_d = seen_q;
                seen_d    = 1'b1;
                sreg_d    = '0;
                bit_cnt_d = '0;
                lr_prev_d = lrclk_s;
            end else begin
                sreg_d = shifted;
                if (bit_cnt_q != MAX_CNT)
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
        end else if (idle_q == IDLE_LAST) begin
            // BCLK lost: drop framing state, keep the last good samples on the outputs
            locked_d  = 1'b0;
            seen_d    = 1'b0;
            slot_ok_d = 1'b0;
            left_ok_d = 1'b0;
            bit_cnt_d = '0;
            sreg_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            lr_prev_q   <= LR_LEFT;
            seen_q      <= 1'b0;
            slot_ok_q   <= 1'b0;
            left_ok_q   <= 1'b0;
            left_hold_q <= '0;
            out_q       <= '0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            idle_q      <= '0;
        end else begin
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            lr_prev_q   <= lr_prev_d;
            seen_q      <= seen_d;
            slot_ok_q   <= slot_ok_d;
            left_ok_q   <= left_ok_d;
            left_hold_q <= left_hold_d;
            out_q       <= out_d;
            locked_q    <= locked_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.left_out     = out_q.left;
    assign bus.right_out    = out_q.right;
    assign bus.sample_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.frame_err    = ferr_q;

endmodule
